// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian push-button front end for the traffic light
// controller. Synchronises and debounces the raw button, latches a crossing
// request until the controller grants walk, and enforces a lockout gap after
// every walk phase.
//
// Optional feature: define PED_REQ_STATS_EN to build the saturating
// accepted-request counter on REQ_CNT; otherwise REQ_CNT is tied to 0.
module ped_request_ctrl #(
  parameter int DEB_CYC  = 20000,
  parameter int DEB_TEST = 4,
  parameter int GAP_CYC  = 100000,
  parameter int GAP_TEST = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TESTMODE,
  input  logic             BTN,
  input  logic             G_PEDES,
  output logic             PED_REQ,
  output logic             WAIT_LAMP,
  output logic [CNT_W-1:0] REQ_CNT
);

  localparam int DEB_MAX = (DEB_CYC > DEB_TEST) ? DEB_CYC : DEB_TEST;
  localparam int GAP_MAX = (GAP_CYC > GAP_TEST) ? GAP_CYC : GAP_TEST;
  localparam int DEB_W   = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_CYC_M1  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_TEST_M1 = DEB_W'(DEB_TEST - 1);
  localparam logic [GAP_W-1:0] GAP_CYC_M1  = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_TEST_M1 = GAP_W'(GAP_TEST - 1);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, LOCKOUT} state_e;

  // Terminal counts follow TESTMODE combinationally so a change takes effect at once.
  logic [DEB_W-1:0] deb_lim_d;
  logic [GAP_W-1:0] gap_lim_d;
  assign deb_lim_d = TESTMODE ? DEB_TEST_M1 : DEB_CYC_M1;
  assign gap_lim_d = TESTMODE ? GAP_TEST_M1 : GAP_CYC_M1;

  logic [1:0]       sync_q;
  logic             deb_q;
  logic             deb_dly_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press_q;

  // Input conditioning: 2-FF synchroniser, stable-count debouncer, rising-edge pulse.
  always_ff @(posedge CLK) begin
    // NOTE: every clocked register uses <= so all flops see pre-edge values;
    // a blocking = here would let the second sync stage see the first stage's new value.
    if (RST) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], BTN};
      if (sync_q[1] != deb_q) begin
        // >= rather than == so a shrinking limit never lets the count run past it.
        if (deb_cnt_q >= deb_lim_d) begin
          deb_q     <= sync_q[1];
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
      deb_dly_q <= deb_q;
      press_q   <= deb_q & ~deb_dly_q;
    end
  end

  state_e           state_q;
  logic [GAP_W-1:0] gap_q;
  logic             deferred_q;
  logic             ped_req_q;
  logic             wait_lamp_q;

  // Request FSM with lockout gap; outputs are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      deferred_q  <= 1'b0;
      ped_req_q   <= 1'b0;
      wait_lamp_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // An unrequested walk wins over a coincident press.
          if (G_PEDES) begin
            state_q     <= SERVING;
            ped_req_q   <= 1'b0;
            wait_lamp_q <= 1'b0;
          end else if (press_q) begin
            state_q     <= PENDING;
            ped_req_q   <= 1'b1;
            wait_lamp_q <= 1'b1;
          end else begin
            ped_req_q   <= 1'b0;
            wait_lamp_q <= 1'b0;
          end
        end
        PENDING: begin
          if (G_PEDES) begin
            state_q     <= SERVING;
            ped_req_q   <= 1'b0;
            wait_lamp_q <= 1'b0;
          end else begin
            ped_req_q   <= 1'b1;
            wait_lamp_q <= 1'b1;
          end
        end
        SERVING: begin
          if (!G_PEDES) begin
            state_q <= LOCKOUT;
            gap_q   <= '0;
          end
          ped_req_q   <= 1'b0;
          wait_lamp_q <= 1'b0;
        end
        LOCKOUT: begin
          if (G_PEDES) begin
            state_q     <= SERVING;
            deferred_q  <= 1'b0;
            ped_req_q   <= 1'b0;
            wait_lamp_q <= 1'b0;
          end else if (gap_q >= gap_lim_d) begin
            // A press arriving on the exit edge is honoured like a deferred one.
            state_q     <= (deferred_q | press_q) ? PENDING : IDLE;
            ped_req_q   <= deferred_q | press_q;
            wait_lamp_q <= deferred_q | press_q;
            deferred_q  <= 1'b0;
            gap_q       <= '0;
          end else begin
            gap_q       <= gap_q + 1'b1;
            deferred_q  <= deferred_q | press_q;
            ped_req_q   <= 1'b0;
            wait_lamp_q <= deferred_q | press_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          deferred_q  <= 1'b0;
          ped_req_q   <= 1'b0;
          wait_lamp_q <= 1'b0;
        end
      endcase
    end
  end

  assign PED_REQ   = ped_req_q;
  assign WAIT_LAMP = wait_lamp_q;

`ifdef PED_REQ_STATS_EN
  logic             accept_d;
  logic [CNT_W-1:0] req_cnt_q;

  // A request is accepted once: from IDLE, or the first press seen during LOCKOUT.
  assign accept_d = press_q & ~G_PEDES &
                    ((state_q == IDLE) || ((state_q == LOCKOUT) && !deferred_q));

  // Saturating accepted-request counter, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_cnt_q <= '0;
    end else if (accept_d && (req_cnt_q != {CNT_W{1'b1}})) begin
      req_cnt_q <= req_cnt_q + 1'b1;
    end
  end

  assign REQ_CNT = req_cnt_q;
`else
  assign REQ_CNT = '0;
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl in TESTMODE (debounce 4, gap 8).
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ped_request_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TESTMODE;
  logic       BTN;
  logic       G_PEDES;
  logic       ped_req, wait_lamp;
  logic [7:0] req_cnt;
  logic       ped_req_s, wait_lamp_s;
  logic [1:0] req_cnt_s;

`ifdef PED_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int acc   = 0;   // accepted requests so far

  always #5 CLK = ~CLK;

  ped_request_ctrl #(.CNT_W(8)) u_dut (
    .CLK(CLK), .RST(RST), .TESTMODE(TESTMODE), .BTN(BTN), .G_PEDES(G_PEDES),
    .PED_REQ(ped_req), .WAIT_LAMP(wait_lamp), .REQ_CNT(req_cnt)
  );

  ped_request_ctrl #(.CNT_W(2)) u_dut_sat (
    .CLK(CLK), .RST(RST), .TESTMODE(TESTMODE), .BTN(BTN), .G_PEDES(G_PEDES),
    .PED_REQ(ped_req_s), .WAIT_LAMP(wait_lamp_s), .REQ_CNT(req_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic exp_req, input logic exp_wait);
    check({tag, "_req"},      32'(ped_req),     32'(exp_req));
    check({tag, "_wait"},     32'(wait_lamp),   32'(exp_wait));
    check({tag, "_req_sat"},  32'(ped_req_s),   32'(exp_req));
    check({tag, "_wait_sat"}, 32'(wait_lamp_s), 32'(exp_wait));
  endtask

  task automatic check_cnt(input string tag);
    int exp_w, exp_s;
    exp_w = STATS ? acc : 0;
    exp_s = STATS ? ((acc > 3) ? 3 : acc) : 0;
    check({tag, "_cnt"},     32'(req_cnt),   32'(exp_w));
    check({tag, "_cnt_sat"}, 32'(req_cnt_s), 32'(exp_s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; TESTMODE = 1'b1; BTN = 1'b1; G_PEDES = 1'b0;

    // Reset held 3 cycles with the button pressed.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_out("rst", 1'b0, 1'b0);
      check_cnt("rst");
    end
    RST = 1'b0; BTN = 1'b0;
    step(10);
    check_out("idle0", 1'b0, 1'b0);

    // Clean press: first sampled at edge k, request visible after edge k+7.
    BTN = 1'b1;
    step(7);
    check_out("press_early", 1'b0, 1'b0);
    step(1);
    check_out("press_req", 1'b1, 1'b1);
    acc = 1;
    check_cnt("press");
    step(2);
    BTN = 1'b0;
    G_PEDES = 1'b1;
    step(1);
    check_out("grant", 1'b0, 1'b0);
    check_cnt("grant");
    step(8);
    G_PEDES = 1'b0;
    step(11);
    check_out("idle1", 1'b0, 1'b0);

    // Short 3-cycle pulse is rejected.
    BTN = 1'b1;
    step(3);
    BTN = 1'b0;
    step(10);
    check_out("short_pulse", 1'b0, 1'b0);

    // Bounce 1,0,1,0 then steady 1: exactly one request.
    BTN = 1'b1; step(1);
    BTN = 1'b0; step(1);
    BTN = 1'b1; step(1);
    BTN = 1'b0; step(1);
    BTN = 1'b1;
    step(7);
    check_out("bounce_early", 1'b0, 1'b0);
    step(1);
    check_out("bounce_req", 1'b1, 1'b1);
    acc = 2;
    check_cnt("bounce");
    step(5);
    check_cnt("bounce_once");
    G_PEDES = 1'b1;
    step(1);
    check_out("bounce_grant", 1'b0, 1'b0);
    BTN = 1'b0;
    step(8);

    // Lockout: press pulse lands 2 edges after G_PEDES is first seen low (edge e).
    BTN = 1'b1;
    step(4);
    G_PEDES = 1'b0;
    step(3);                             // after edge e+2
    check_out("lock_pre", 1'b0, 1'b0);
    step(1);                             // after edge e+3
    check_out("lock_defer", 1'b0, 1'b1);
    acc = 3;
    check_cnt("lock_defer");
    step(4);                             // after edge e+7
    check_out("lock_gap", 1'b0, 1'b1);
    step(1);                             // after edge e+8
    check_out("lock_exit", 1'b1, 1'b1);
    check_cnt("lock_exit");
    G_PEDES = 1'b1;
    BTN = 1'b0;
    step(1);
    check_out("lock_serve", 1'b0, 1'b0);
    step(8);
    G_PEDES = 1'b0;
    step(11);
    check_out("idle2", 1'b0, 1'b0);

    // Unrequested walk arriving on the same edge as a press.
    BTN = 1'b1;
    step(7);
    G_PEDES = 1'b1;
    step(1);
    check_out("unreq", 1'b0, 1'b0);
    check_cnt("unreq");
    step(2);
    check_out("unreq_hold", 1'b0, 1'b0);
    BTN = 1'b0;
    step(8);
    G_PEDES = 1'b0;
    step(11);

    // Requests 4 and 5, with a repeat press while pending that must not count.
    BTN = 1'b1;
    step(8);
    check_out("req4", 1'b1, 1'b1);
    acc = 4;
    check_cnt("req4");
    BTN = 1'b0;
    step(8);
    BTN = 1'b1;
    step(10);
    check_out("req4_dup", 1'b1, 1'b1);
    check_cnt("req4_dup");
    G_PEDES = 1'b1;
    step(1);
    BTN = 1'b0;
    step(8);
    G_PEDES = 1'b0;
    step(11);
    BTN = 1'b1;
    step(8);
    check_out("req5", 1'b1, 1'b1);
    acc = 5;
    check_cnt("req5_sat");

    // Slow timing ignores a 30-cycle hold; switching back terminates on the next edge.
    G_PEDES = 1'b1;
    step(1);
    BTN = 1'b0;
    step(8);
    G_PEDES = 1'b0;
    step(11);
    TESTMODE = 1'b0;
    BTN = 1'b1;
    step(30);
    check_out("slow_hold", 1'b0, 1'b0);
    TESTMODE = 1'b1;
    step(2);
    check_out("mode_switch_early", 1'b0, 1'b0);
    step(1);
    check_out("mode_switch_req", 1'b1, 1'b1);
    acc = 6;
    check_cnt("mode_switch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
